lowpass_fir_mc: RTL

- Multi-channel, time-division-multiplexed, decimating low-pass FIR. Successor to the single-channel lowpass_fir.
- Adds NUM_CH interleaved channels with independent delay lines, runtime-loadable coefficients and a per-channel decimation factor.
- Uses one serial MAC with a valid/ready input handshake.
- Sits between the sample source and the downstream rate-reduced processing chain.

---
 rtl/lowpass_fir_mc.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lowpass_fir_mc.sv
// Multi-channel TDM decimating low-pass FIR: per-channel circular delay lines,
// shared runtime-loadable coefficients and one serial MAC behind a valid/ready input.
module lowpass_fir_mc #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned TAP_CNT   = 31,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned GAIN_W    = 4,
  parameter int unsigned DECIM_MAX = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  valid_in,
  output logic                                  ready_in,
  // one spare bit so out-of-range channel codes can be presented and discarded
  input  logic [$clog2(NUM_CH+1)-1:0]           ch_in,
  input  logic signed [DATA_W-1:0]              data_in,
  input  logic [$clog2(DECIM_MAX+1)-1:0]        decim,
  input  logic                                  coef_we,
  input  logic [$clog2(TAP_CNT)-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0]              coef_data,
  output logic                                  valid_out,
  output logic [$clog2(NUM_CH)-1:0]             ch_out,
  output logic signed [DATA_W+GAIN_W-1:0]       data_out,
  output logic                                  busy
);

  localparam int unsigned CH_W   = $clog2(NUM_CH);
  localparam int unsigned CHI_W  = $clog2(NUM_CH + 1);
  localparam int unsigned AW     = $clog2(TAP_CNT);
  localparam int unsigned DW     = $clog2(DECIM_MAX + 1);
  localparam int unsigned OUT_W  = DATA_W + GAIN_W;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAP_CNT);

  localparam logic [AW-1:0]    TAP_LAST = AW'(TAP_CNT - 1);
  localparam logic [CHI_W-1:0] CH_LIM   = CHI_W'(NUM_CH);
  localparam logic [DW-1:0]    D_MAX    = DW'(DECIM_MAX);
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic signed [COEF_W-1:0] r_coef  [TAP_CNT];
  logic signed [DATA_W-1:0] r_dline [NUM_CH][TAP_CNT];
  logic [AW-1:0]            r_wp    [NUM_CH];
  logic [DW-1:0]            r_phase [NUM_CH];

  logic                     r_ready;
  logic                     r_busy;
  logic                     r_valid;
  logic [CH_W-1:0]          r_ch_out;
  logic signed [OUT_W-1:0]  r_dout;

  logic [CH_W-1:0]          r_ch;
  logic [AW-1:0]            r_rd_ptr;
  logic [AW-1:0]            r_cidx;
  logic signed [ACC_W-1:0]  r_acc;

  logic                     w_accept;
  logic                     w_ch_ok;
  logic [CH_W-1:0]          w_ch;
  logic [DW-1:0]            w_decim_eff;
  logic                     w_fire;
  logic [AW-1:0]            w_wp_nx;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [OUT_W-1:0]  w_sat;

  assign ready_in  = r_ready;
  assign busy      = r_busy;
  assign valid_out = r_valid;
  assign ch_out    = r_ch_out;
  assign data_out  = r_dout;

  // Accept decode: effective decimation is decim clamped to 1..DECIM_MAX
  always_comb begin
    w_accept    = valid_in & r_ready;
    w_ch_ok     = (ch_in < CH_LIM);
    w_ch        = CH_W'(ch_in);
    w_decim_eff = decim;
    if (decim == '0) begin
      w_decim_eff = DW'(1);
    end else if (decim > D_MAX) begin
      w_decim_eff = D_MAX;
    end
    w_fire  = w_accept & w_ch_ok & (r_phase[w_ch] >= (w_decim_eff - DW'(1)));
    w_wp_nx = (r_wp[w_ch] == TAP_LAST) ? '0 : r_wp[w_ch] + AW'(1);
  end

  // MAC product and output scaling with saturation to the output range
  always_comb begin
    w_prod  = PROD_W'(r_dline[r_ch][r_rd_ptr]) * PROD_W'(r_coef[r_cidx]);
    w_shift = r_acc >>> (COEF_W - 1);
    if (w_shift > SAT_HI) begin
      w_sat = OUT_W'(SAT_HI);
    end else if (w_shift < SAT_LO) begin
      w_sat = OUT_W'(SAT_LO);
    end else begin
      w_sat = OUT_W'(w_shift);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_fire) w_state_nx = S_MAC;
      S_MAC:   if (r_cidx == '0) w_state_nx = S_OUT;
      S_OUT:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Handshake and status flags track the next state so they are registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_ready <= (w_state_nx == S_IDLE);
      r_busy  <= (w_state_nx != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_coef   <= '{default: '0};
      r_dline  <= '{default: '{default: '0}};
      r_wp     <= '{default: '0};
      r_phase  <= '{default: '0};
      r_valid  <= 1'b0;
      r_ch_out <= '0;
      r_dout   <= '0;
      r_ch     <= '0;
      r_rd_ptr <= '0;
      r_cidx   <= '0;
      r_acc    <= '0;
    end else begin
      r_valid <= 1'b0;

      if ((r_state == S_IDLE) && coef_we && (coef_addr <= TAP_LAST)) begin
        r_coef[coef_addr] <= coef_data;
      end

      // Store sample; on a decimating accept the MAC starts at the oldest tap
      if (w_accept && w_ch_ok) begin
        r_dline[w_ch][r_wp[w_ch]] <= data_in;
        r_wp[w_ch]                <= w_wp_nx;
        if (w_fire) begin
          r_phase[w_ch] <= '0;
          r_ch          <= w_ch;
          r_rd_ptr      <= w_wp_nx;
          r_cidx        <= TAP_LAST;
          r_acc         <= '0;
        end else begin
          r_phase[w_ch] <= r_phase[w_ch] + DW'(1);
        end
      end

      if (r_state == S_MAC) begin
        r_acc    <= r_acc + ACC_W'(w_prod);
        r_rd_ptr <= (r_rd_ptr == TAP_LAST) ? '0 : r_rd_ptr + AW'(1);
        r_cidx   <= r_cidx - AW'(1);
      end

      if (r_state == S_OUT) begin
        r_valid  <= 1'b1;
        r_dout   <= w_sat;
        r_ch_out <= r_ch;
      end
    end
  end

endmodule
